morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive-side counterpart of the LED SOS pattern generator.
- Samples a single on/off line (push-button or optical/LED loopback) at a slow time-unit tick, then classifies each mark as a dot or dash and each space as an element, character or word gap.
- Emits ASCII characters one at a time on a valid strobe, and flags the SOS prosign separately.
- Sits behind the PLL clock, next to the slow-tick counter; shares the same rst.

Parameters:
DOT_MAX, 2, longest mark (ticks) classified as dot; DOT_MAX+1..DASH_MAX is dash
DASH_MAX, 6, longest legal mark; longer marks poison the current character
CHAR_GAP, 3, space length (ticks) that terminates a character
WORD_GAP, 7, space length (ticks) that emits a word space; must be > CHAR_GAP
CNT_W, 8, width of the mark/gap tick counters (saturating)

Ports:
clk  in  1  system clock (PLL output)
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle strobe, one per Morse time unit
din  in  1  raw mark input, asynchronous, 1 = mark (key down / LED on)
sym_valid  out  1  one-cycle pulse: sym holds a decoded character
sym  out  8  ASCII: 'A'-'Z', '0'-'9', ' ' (word gap), '?' (invalid)
sos  out  1  one-cycle pulse when the element sequence ...---... completes (no sym_valid for it)
busy  out  1  high while in MARK or GAP state

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; counters, code register and length cleared; sym_valid=0, sym=8'h00, sos=0, busy=0. Reset mid-character discards the partial character with no output.
- Input conditioning:
  - din passes through a 2-FF synchronizer.
  - The level is evaluated only on cycles with tick=1, so glitches shorter than one tick between samples are ignored.
- Code store:
  - 9-bit shift register; new element shifts into bit 0; 1=dash, 0=dot.
  - 4-bit length; a 10th element sets the overflow flag, and the register stops changing.
- States and transitions (all evaluated on tick cycles only):
  - IDLE, level 1: mark_cnt=1, go to MARK. Level 0: stay.
  - MARK, level 1: mark_cnt++ (saturating at 2^CNT_W-1); mark_cnt>DASH_MAX sets the bad flag.
  - MARK, level 0: classify — 1..DOT_MAX is a dot, else a dash; append unless bad or overflow. Then gap_cnt=1, go to GAP.
  - GAP, level 1: mark_cnt=1, go to MARK (same character if no character was emitted yet).
  - GAP, level 0: gap_cnt++ (saturating).
    - When gap_cnt becomes CHAR_GAP, emit the character and clear code, length and flags.
    - When gap_cnt becomes WORD_GAP, emit ' ' and go to IDLE.
- Emission:
  - Outputs are registered: sym_valid/sos rise on the clock edge ending the tick cycle that reaches the threshold, and last exactly one cycle.
  - sym holds its value until the next emission.
- Decode of length and code:
  - Letters A–Z and digits 0–9 per ITU-R M.1677 map to ASCII.
  - Length 9 with code 9'b000111000 pulses sos instead of sym_valid.
  - Any other pattern, or the bad or overflow flag set, emits '?'.
- Word space: emitted once per gap, only after at least one character since the last word space or reset. A gap from IDLE never emits.
- tick while rst=1 is ignored. tick is never required on consecutive cycles, and back-to-back ticks are legal.
- busy is 1 in MARK/GAP and 0 in IDLE.

Test Plan:
- Reset: hold rst 3 cycles with din=1 and ticks running -> sym_valid=0, sym=0x00, busy=0; first tick after release enters MARK.
- Letter A: mark 1 tick, space 1, mark 3, space 3 -> one sym_valid pulse with sym=0x41, exactly one cycle after the 3rd space tick; then space to 7 ticks total -> sym=0x20 pulse, state IDLE.
- SOS: dots of 1 tick and dashes of 3, 1-tick intra gaps, then 3-tick gap -> sos pulses once, sym_valid stays 0.
- Digits and boundaries:
  - "0" (5 dashes of 3 ticks) -> sym=0x30.
  - Mark of exactly 2 ticks = dot, 3 ticks = dash: "E" (one 2-tick mark) -> 0x45; "T" (one 3-tick mark) -> 0x54.
- Errors:
  - 8-tick mark then 3-tick gap -> sym=0x3F.
  - 10 dots -> 0x3F.
  - ".-.-" (unassigned) -> 0x3F.
- Robustness:
  - 1-cycle din glitch between ticks -> no state change.
  - rst asserted after 2 elements -> no output, next character decodes cleanly.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse receiver: samples a keyed on/off line at the time-unit tick, classifies marks and
// spaces, and emits ASCII characters on a one-cycle strobe with a separate SOS prosign pulse.
module morse_decoder #(
   parameter int DOT_MAX  = 2,
   parameter int DASH_MAX = 6,
   parameter int CHAR_GAP = 3,
   parameter int WORD_GAP = 7,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       din,
   output logic       sym_valid,
   output logic [7:0] sym,
   output logic       sos,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DOT_THR  = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_MAX);
   localparam logic [CNT_W-1:0] CHAR_THR = CNT_W'(CHAR_GAP);
   localparam logic [CNT_W-1:0] WORD_THR = CNT_W'(WORD_GAP);
   localparam logic [8:0]       SOS_CODE = 9'b000111000;
   localparam logic [3:0]       LEN_MAX  = 4'd9;

   state_t           state, state_nx;
   logic             din_meta, din_sync;
   logic [CNT_W-1:0] mark_cnt, mark_nx;
   logic [CNT_W-1:0] gap_cnt, gap_nx;
   logic [8:0]       code, code_nx;
   logic [3:0]       len, len_nx;
   logic             bad, bad_nx;
   logic             ovf, ovf_nx;
   logic             have_char, have_nx;
   logic             sym_valid_nx, sos_nx;
   logic [7:0]       sym_nx;

   // ITU-R M.1677 letters and digits; first element sits in the highest used code bit.
   function automatic logic [7:0] decode(input logic [3:0] n, input logic [8:0] c);
      logic [8:0] key;
      logic [7:0] ch;
      key = {n, c[4:0]};
      ch  = 8'h3F;
      case (key)
         {4'd2, 5'b00001}: ch = "A";
         {4'd4, 5'b01000}: ch = "B";
         {4'd4, 5'b01010}: ch = "C";
         {4'd3, 5'b00100}: ch = "D";
         {4'd1, 5'b00000}: ch = "E";
         {4'd4, 5'b00010}: ch = "F";
         {4'd3, 5'b00110}: ch = "G";
         {4'd4, 5'b00000}: ch = "H";
         {4'd2, 5'b00000}: ch = "I";
         {4'd4, 5'b00111}: ch = "J";
         {4'd3, 5'b00101}: ch = "K";
         {4'd4, 5'b00100}: ch = "L";
         {4'd2, 5'b00011}: ch = "M";
         {4'd2, 5'b00010}: ch = "N";
         {4'd3, 5'b00111}: ch = "O";
         {4'd4, 5'b00110}: ch = "P";
         {4'd4, 5'b01101}: ch = "Q";
         {4'd3, 5'b00010}: ch = "R";
         {4'd3, 5'b00000}: ch = "S";
         {4'd1, 5'b00001}: ch = "T";
         {4'd3, 5'b00001}: ch = "U";
         {4'd4, 5'b00001}: ch = "V";
         {4'd3, 5'b00011}: ch = "W";
         {4'd4, 5'b01001}: ch = "X";
         {4'd4, 5'b01011}: ch = "Y";
         {4'd4, 5'b01100}: ch = "Z";
         {4'd5, 5'b11111}: ch = "0";
         {4'd5, 5'b01111}: ch = "1";
         {4'd5, 5'b00111}: ch = "2";
         {4'd5, 5'b00011}: ch = "3";
         {4'd5, 5'b00001}: ch = "4";
         {4'd5, 5'b00000}: ch = "5";
         {4'd5, 5'b10000}: ch = "6";
         {4'd5, 5'b11000}: ch = "7";
         {4'd5, 5'b11100}: ch = "8";
         {4'd5, 5'b11110}: ch = "9";
         default:          ch = 8'h3F;
      endcase
      return ch;
   endfunction

   // NOTE: synchronizer flops carry no reset so they keep tracking din while rst is held.
   always_ff @(posedge clk) begin
      din_meta <= din;
      din_sync <= din_meta;
   end

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      state_nx     = state;
      mark_nx      = mark_cnt;
      gap_nx       = gap_cnt;
      code_nx      = code;
      len_nx       = len;
      bad_nx       = bad;
      ovf_nx       = ovf;
      have_nx      = have_char;
      sym_nx       = sym;
      sym_valid_nx = 1'b0;
      sos_nx       = 1'b0;

      if (tick) begin
         case (state)
            IDLE: begin
               if (din_sync) begin
                  mark_nx  = CNT_ONE;
                  state_nx = MARK;
               end
            end

            MARK: begin
               if (din_sync) begin
                  if (mark_cnt != CNT_MAX) mark_nx = mark_cnt + CNT_ONE;
                  if (mark_nx > DASH_THR) bad_nx = 1'b1;
               end else begin
                  if (!bad) begin
                     if (len == LEN_MAX) begin
                        ovf_nx = 1'b1;
                     end else begin
                        code_nx = {code[7:0], (mark_cnt > DOT_THR)};
                        len_nx  = len + 4'd1;
                     end
                  end
                  gap_nx   = CNT_ONE;
                  state_nx = GAP;
               end
            end

            GAP: begin
               if (din_sync) begin
                  mark_nx  = CNT_ONE;
                  state_nx = MARK;
               end else begin
                  if (gap_cnt != CNT_MAX) gap_nx = gap_cnt + CNT_ONE;
                  if (gap_nx == CHAR_THR) begin
                     if (bad || ovf) begin
                        sym_valid_nx = 1'b1;
                        sym_nx       = 8'h3F;
                        have_nx      = 1'b1;
                     end else if (len == LEN_MAX && code == SOS_CODE) begin
                        sos_nx = 1'b1;
                     end else begin
                        sym_valid_nx = 1'b1;
                        sym_nx       = decode(len, code);
                        have_nx      = 1'b1;
                     end
                     code_nx = '0;
                     len_nx  = '0;
                     bad_nx  = 1'b0;
                     ovf_nx  = 1'b0;
                  end
                  if (gap_nx == WORD_THR) begin
                     if (have_char) begin
                        sym_valid_nx = 1'b1;
                        sym_nx       = 8'h20;
                        have_nx      = 1'b0;
                     end
                     state_nx = IDLE;
                  end
               end
            end

            default: state_nx = IDLE;
         endcase
      end
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mark_cnt  <= '0;
         gap_cnt   <= '0;
         code      <= '0;
         len       <= '0;
         bad       <= 1'b0;
         ovf       <= 1'b0;
         have_char <= 1'b0;
         sym       <= 8'h00;
         sym_valid <= 1'b0;
         sos       <= 1'b0;
      end else begin
         state     <= state_nx;
         mark_cnt  <= mark_nx;
         gap_cnt   <= gap_nx;
         code      <= code_nx;
         len       <= len_nx;
         bad       <= bad_nx;
         ovf       <= ovf_nx;
         have_char <= have_nx;
         sym       <= sym_nx;
         sym_valid <= sym_valid_nx;
         sos       <= sos_nx;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: a dot/dash string model builds a per-tick expectation plan
// from segment lengths; directed cases cover the named boundaries, then random traffic.
module tb_morse_decoder;

   localparam int DOT_MAX  = 2;
   localparam int DASH_MAX = 6;
   localparam int CHAR_GAP = 3;
   localparam int WORD_GAP = 7;
   localparam int CNT_W    = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       din = 1'b0;
   logic       sym_valid;
   logic [7:0] sym;
   logic       sos;
   logic       busy;

   morse_decoder #(
      .DOT_MAX (DOT_MAX),
      .DASH_MAX(DASH_MAX),
      .CHAR_GAP(CHAR_GAP),
      .WORD_GAP(WORD_GAP),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .din      (din),
      .sym_valid(sym_valid),
      .sym      (sym),
      .sos      (sos),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         lvl;
      bit         v;
      logic [7:0] s;
      bit         so;
      bit         bz;
   } step_t;

   step_t plan[$];

   string tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                      "---..", "----."};

   int         n_checks = 0;
   int         n_fail   = 0;
   int         tick_no  = 0;
   bit         cur_lvl  = 1'b0;

   string      m_cur;
   bit         m_bad, m_ovf, m_have, m_active;
   logic [7:0] m_sym;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, tick_no);
      end
   endtask

   task automatic push(input bit lvl, input bit v, input bit so, input bit bz);
      step_t st;
      st.lvl = lvl;
      st.v   = v;
      st.s   = m_sym;
      st.so  = so;
      st.bz  = bz;
      plan.push_back(st);
   endtask

   task automatic model_reset();
      m_cur    = "";
      m_bad    = 1'b0;
      m_ovf    = 1'b0;
      m_have   = 1'b0;
      m_active = 1'b0;
      m_sym    = 8'h00;
   endtask

   task automatic add_mark(input int len_t);
      for (int i = 0; i < len_t; i++) push(1'b1, 1'b0, 1'b0, 1'b1);
      m_active = 1'b1;
      if (len_t > DASH_MAX) m_bad = 1'b1;
      else if (!m_bad) begin
         if (m_cur.len() >= 9) m_ovf = 1'b1;
         else if (len_t <= DOT_MAX) m_cur = {m_cur, "."};
         else m_cur = {m_cur, "-"};
      end
   endtask

   // Character boundary: decide the outcome of the collected elements and push that tick.
   task automatic emit_char();
      logic [7:0] ch;
      bit         is_sos;
      ch     = 8'h3F;
      is_sos = 1'b0;
      if (!(m_bad || m_ovf)) begin
         if (m_cur == "...---...") is_sos = 1'b1;
         else
            for (int i = 0; i < 36; i++)
               if (m_cur == tab[i]) ch = (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
      end
      if (is_sos) push(1'b0, 1'b0, 1'b1, 1'b1);
      else begin
         m_sym  = ch;
         m_have = 1'b1;
         push(1'b0, 1'b1, 1'b0, 1'b1);
      end
      m_cur = "";
      m_bad = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic add_gap(input int len_t);
      for (int i = 1; i <= len_t; i++) begin
         if (!m_active) push(1'b0, 1'b0, 1'b0, 1'b0);
         else if (i == CHAR_GAP) emit_char();
         else if (i == WORD_GAP) begin
            if (m_have) begin
               m_sym  = 8'h20;
               m_have = 1'b0;
               push(1'b0, 1'b1, 1'b0, 1'b0);
            end else push(1'b0, 1'b0, 1'b0, 1'b0);
            m_active = 1'b0;
         end else push(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic add_pattern(input string pat, input int tail_gap);
      for (int j = 0; j < pat.len(); j++) begin
         add_mark(pat[j] == "." ? 1 : 3);
         if (j < pat.len() - 1) add_gap(1);
      end
      add_gap(tail_gap);
   endtask

   // Called on a negedge; returns on the negedge after the tick edge, outputs checked.
   task automatic do_tick(input step_t st);
      bit glitch, fast;
      glitch = ($urandom_range(0, 9) == 0);
      fast   = (st.lvl == cur_lvl) && !glitch && ($urandom_range(0, 2) == 0);
      if (!fast) begin
         if (glitch) begin
            din = ~st.lvl;
            @(negedge clk);
         end
         din = st.lvl;
         repeat (3 + $urandom_range(0, 2)) begin
            @(negedge clk);
            check("between_valid", sym_valid, 1'b0);
            check("between_sos", sos, 1'b0);
         end
      end
      tick = 1'b1;
      @(negedge clk);
      tick    = 1'b0;
      cur_lvl = st.lvl;
      tick_no++;
      check("sym_valid", sym_valid, st.v);
      check("sos", sos, st.so);
      check("busy", busy, st.bz);
      check("sym", sym, st.s);
   endtask

   task automatic run_plan();
      while (plan.size() > 0) do_tick(plan.pop_front());
   endtask

   task automatic apply_reset();
      @(negedge clk);
      din  = 1'b1;
      rst  = 1'b1;
      tick = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_valid", sym_valid, 1'b0);
         check("rst_sym", sym, 8'h00);
         check("rst_busy", busy, 1'b0);
         check("rst_sos", sos, 1'b0);
      end
      rst     = 1'b0;
      tick    = 1'b0;
      cur_lvl = 1'b1;
      model_reset();
   endtask

   initial begin
      string pat;
      int    k;
      model_reset();
      apply_reset();

      // Letter A followed by a word space.
      add_mark(1); add_gap(1); add_mark(3); add_gap(WORD_GAP);
      run_plan();

      // SOS prosign, then E to close the word.
      add_pattern("...---...", 4);
      add_mark(1); add_gap(WORD_GAP);
      run_plan();

      // Digit 0, then dot/dash boundary: 2 ticks = E, 3 ticks = T.
      add_pattern("-----", WORD_GAP);
      add_mark(DOT_MAX); add_gap(WORD_GAP);
      add_mark(DOT_MAX + 1); add_gap(WORD_GAP);
      run_plan();

      // Errors: overlong mark, ten dots, unassigned pattern.
      add_mark(8); add_gap(WORD_GAP);
      add_pattern("..........", WORD_GAP);
      add_pattern(".-.-", WORD_GAP);
      run_plan();

      // Reset mid-character, then N decodes cleanly.
      add_mark(1); add_gap(1); add_mark(3); add_gap(1);
      run_plan();
      apply_reset();
      add_mark(3); add_gap(1); add_mark(1); add_gap(WORD_GAP);
      run_plan();

      // Random traffic mixing legal characters, garbage and odd timings.
      repeat (60) begin
         k = $urandom_range(0, 39);
         if (k < 36) pat = tab[k];
         else begin
            pat = "";
            repeat ($urandom_range(1, 10)) pat = {pat, ($urandom_range(0, 1) == 0) ? "." : "-"};
         end
         for (int j = 0; j < pat.len(); j++) begin
            int len_t;
            if (pat[j] == ".") len_t = $urandom_range(1, DOT_MAX);
            else len_t = $urandom_range(DOT_MAX + 1, DASH_MAX);
            if ($urandom_range(0, 19) == 0) len_t = $urandom_range(DASH_MAX + 1, DASH_MAX + 3);
            add_mark(len_t);
            if (j < pat.len() - 1) add_gap($urandom_range(1, CHAR_GAP - 1));
         end
         if ($urandom_range(0, 2) == 0) begin
            add_gap($urandom_range(WORD_GAP, WORD_GAP + 3));
            add_gap($urandom_range(0, 3));
         end else add_gap($urandom_range(CHAR_GAP, WORD_GAP - 1));
         run_plan();
      end
      add_gap(WORD_GAP);
      run_plan();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
